// File: rtl/osc_capture_pkg.sv
// Shared types and helpers for the oscilloscope acquisition/trigger stage.
package osc_capture_pkg;
    localparam int ADC_CODE_W = 12;

    typedef enum logic [2:0] {IDLE, PREFILL, ARMED, POST, DONE} capture_state_e;
    typedef enum logic [1:0] {AUTO = 2'd0, NORMAL = 2'd1, SINGLE = 2'd2} trig_mode_e;

    // XADC places the 12-bit conversion in the top bits of a 16-bit word.
    function automatic logic [ADC_CODE_W-1:0] adc_code(input logic [15:0] word);
        return word[15:4];
    endfunction
endpackage

// File: rtl/capture_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module capture_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Output register reset maps onto the BRAM output-register reset.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/adc_trigger_capture.sv
// Decimating trigger/capture stage with pre-trigger history in block RAM.
// Optional hysteresis arming of the edge detector: define CAPTURE_TRIG_HYST_EN.
module adc_trigger_capture
    import osc_capture_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int PRE_TRIG     = 256,
    parameter int AUTO_TIMEOUT = 2048,
    parameter int HYST         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [15:0]       decim,
    input  logic [11:0]       trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        trig_mode,
    input  logic              arm,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_ready,
    output logic              busy,
    output logic              triggered
);
`ifdef CAPTURE_TRIG_HYST_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif
    localparam int POST_N = DEPTH - PRE_TRIG - 1;

    capture_state_e          state;
    logic [15:0]             decim_lat, dcnt;
    logic [ADDR_W-1:0]       wr_ptr, trig_ptr, rd_phys;
    logic [ADC_CODE_W-1:0]   prev_code, code;
    logic                    prev_vld, hyst_arm;
    logic [31:0]             cnt;
    logic                    in_capture, dsample, rise, fall, edge_hit, timeout, hyst_set;
    logic [ADC_CODE_W:0]     lvl_ext, hyst_lo, hyst_hi;

    assign in_capture = (state == PREFILL) || (state == ARMED) || (state == POST);
    assign dsample    = sample_valid && in_capture && (dcnt == decim_lat);
    assign code       = adc_code(sample_in[DATA_W-1 -: 16]);

    assign rise = prev_vld && (prev_code <  trig_level) && (code >= trig_level);
    assign fall = prev_vld && (prev_code >  trig_level) && (code <= trig_level);

    // Hysteresis window, saturated to the ADC code range.
    assign lvl_ext  = {1'b0, trig_level};
    assign hyst_lo  = (lvl_ext < (ADC_CODE_W+1)'(HYST)) ? '0 : lvl_ext - (ADC_CODE_W+1)'(HYST);
    assign hyst_hi  = (lvl_ext + (ADC_CODE_W+1)'(HYST) > (ADC_CODE_W+1)'(4095)) ?
                      (ADC_CODE_W+1)'(4095) : lvl_ext + (ADC_CODE_W+1)'(HYST);
    assign hyst_set = trig_slope ? ({1'b0, code} < hyst_lo) : ({1'b0, code} > hyst_hi);

    assign edge_hit = (trig_slope ? rise : fall) && (hyst_arm || !HYST_EN);
    assign timeout  = (trig_mode == AUTO) && (cnt >= 32'(AUTO_TIMEOUT - 1));
    assign rd_phys  = trig_ptr - ADDR_W'(PRE_TRIG) + rd_addr;

    capture_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (dsample),
        .wr_addr (wr_ptr),
        .wr_data (sample_in),
        .rd_addr (rd_phys),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            decim_lat   <= '0;
            dcnt        <= '0;
            wr_ptr      <= '0;
            trig_ptr    <= '0;
            prev_code   <= '0;
            prev_vld    <= 1'b0;
            hyst_arm    <= 1'b0;
            cnt         <= '0;
            frame_ready <= 1'b0;
            busy        <= 1'b0;
            triggered   <= 1'b0;
        end else begin
            if (sample_valid && in_capture)
                dcnt <= (dcnt == decim_lat) ? '0 : dcnt + 16'd1;
            if (dsample) begin
                wr_ptr    <= wr_ptr + 1'b1;
                prev_code <= code;
                prev_vld  <= 1'b1;
                if (hyst_set)
                    hyst_arm <= 1'b1;
            end
            // State actions below are ordered after the datapath so that
            // a trigger's latch clear wins over a same-sample latch set.
            case (state)
                IDLE: if (arm) begin
                    state     <= PREFILL;
                    busy      <= 1'b1;
                    decim_lat <= decim;
                    dcnt      <= '0;
                    prev_vld  <= 1'b0;
                    hyst_arm  <= 1'b0;
                    cnt       <= '0;
                end
                PREFILL: if (dsample) begin
                    if (cnt == 32'(PRE_TRIG - 1)) begin
                        state <= ARMED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ARMED: if (dsample) begin
                    if (edge_hit || timeout) begin
                        trig_ptr    <= wr_ptr;
                        triggered   <= edge_hit;
                        hyst_arm    <= 1'b0;
                        cnt         <= '0;
                        state       <= (POST_N == 0) ? DONE : POST;
                        busy        <= (POST_N != 0);
                        frame_ready <= (POST_N == 0);
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                POST: if (dsample) begin
                    if (cnt == 32'(POST_N - 1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        frame_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DONE: if (frame_ack) begin
                    frame_ready <= 1'b0;
                    if (trig_mode == SINGLE) begin
                        state <= IDLE;
                    end else begin
                        state     <= PREFILL;
                        busy      <= 1'b1;
                        decim_lat <= decim;
                        dcnt      <= '0;
                        prev_vld  <= 1'b0;
                        hyst_arm  <= 1'b0;
                        cnt       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/adc_trigger_capture.md
Name: adc_trigger_capture

Overview:
Acquisition stage directly upstream of the scale/offset converter. Takes the raw XADC sample stream and decimates it per the timebase setting. Detects the trigger condition and stores one frame with pre-trigger history in block RAM. The display scanner reads the frozen frame by logical index, and `rd_data` drives the converter's 16-bit `data_in` (12-bit code in [15:4]).

Parameters:
- DATA_W, 16: sample width; 12-bit ADC code occupies [DATA_W-1:DATA_W-12].
- DEPTH, 1024: samples per frame; power of two.
- ADDR_W, $clog2(DEPTH): buffer address width (derived).
- PRE_TRIG, 256: samples kept before the trigger sample; must be < DEPTH.
- AUTO_TIMEOUT, 2048: decimated samples in ARMED before auto mode forces a trigger.
- HYST, 8: hysteresis in ADC codes (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_valid  in  1  one-cycle strobe per new ADC conversion
- sample_in  in  DATA_W  raw XADC word
- decim  in  16  keep one of every decim+1 samples
- trig_level  in  12  trigger threshold (ADC code)
- trig_slope  in  1  1 = rising edge, 0 = falling edge
- trig_mode  in  2  0 = auto, 1 = normal, 2 = single, 3 = treated as normal
- arm  in  1  pulse; starts capture from IDLE
- frame_ack  in  1  pulse; display finished reading the frame
- rd_addr  in  ADDR_W  logical index, 0 = oldest sample
- rd_data  out  DATA_W  frame sample; registered, 1-cycle latency
- frame_ready  out  1  frame frozen and readable
- busy  out  1  state is PREFILL, ARMED or POST
- triggered  out  1  1 = last frame from a real edge; 0 = forced by auto timeout

Behaviour:
- Reset: state IDLE; rd_data, frame_ready, busy, triggered = 0; all counters and pointers = 0. RAM contents are not cleared. Reset in any state aborts the capture immediately.
- Decimation:
  - `decim` is latched on entry to PREFILL; the decimation counter clears on that entry.
  - A sample_valid with counter == latched decim is a decimated sample (dsample); the counter then returns to 0. Otherwise the counter increments.
  - sample_valid is ignored in IDLE and DONE.
- Write path: each dsample in PREFILL, ARMED or POST writes RAM[wr_ptr], then wr_ptr = (wr_ptr + 1) mod DEPTH.
- Edge detection:
  - Compares the current dsample code c with the previous dsample code p. p is invalid after PREFILL entry until one dsample has arrived.
  - Rising edge: p < trig_level && c >= trig_level.
  - Falling edge: p > trig_level && c <= trig_level.
- States:
  - IDLE: arm -> PREFILL.
  - PREFILL: write PRE_TRIG dsamples; edges ignored; then -> ARMED.
  - ARMED:
    - On each dsample, an edge -> POST with triggered = 1. The edge sample's address is stored as trig_ptr.
    - Auto mode: AUTO_TIMEOUT dsamples without an edge force POST with triggered = 0, using the current sample as trig_ptr.
    - An edge and the timeout on the same dsample count as a real trigger.
  - POST: write DEPTH-PRE_TRIG-1 more dsamples, then -> DONE.
  - DONE:
    - frame_ready = 1; writes stop.
    - frame_ack -> PREFILL for auto and normal modes, -> IDLE for single mode. frame_ready drops on the same edge.
- Outputs: busy = 1 exactly in PREFILL, ARMED and POST. triggered holds its value until the next trigger event.
- Read path:
  - rd_data <= RAM[(trig_ptr - PRE_TRIG + rd_addr) mod DEPTH] on every clk.
  - Data is valid to the consumer only while frame_ready = 1; rd_addr = PRE_TRIG returns the trigger sample.
- Ignored inputs: arm outside IDLE; frame_ack outside DONE.
- Input changes mid-capture: trig_level, trig_slope and trig_mode changes take effect on the next dsample; decim changes wait for the next PREFILL.

Optional Feature:
- Macro: CAPTURE_TRIG_HYST_EN.
- Defined: an edge requires prior arming of a hysteresis latch.
  - Rising: latch sets when c < trig_level - HYST (saturating at 0).
  - Falling: latch sets when c > trig_level + HYST (saturating at 4095).
  - The latch clears on PREFILL entry and after each trigger. This suppresses noise retriggers.
- Undefined: plain crossing detection as above; HYST unused.

Decomposition:
- Package osc_capture_pkg:
  - capture_state_e (IDLE, PREFILL, ARMED, POST, DONE)
  - trig_mode_e (AUTO, NORMAL, SINGLE)
  - ADC_CODE_W = 12
  - function adc_code() extracting [15:4]
- Sub-module capture_ram: simple dual-port RAM, DEPTH x DATA_W, write port + registered read port, inferred BRAM.

Test Plan:
1. Reset check: assert rst for 3 cycles mid-POST -> rd_data, frame_ready, busy, triggered = 0 and state IDLE next cycle; a subsequent arm starts PREFILL normally.
2. Normal mode, rising edge:
   - Setup: decim = 0, trig_level = 2048; ramp sample_in = n<<4 for n = 0..4095 with sample_valid every 4 cycles; arm.
   - Trigger at code 2048; frame_ready after 767 further samples.
   - rd_addr = 256 -> 0x8000; rd_addr = 0 -> 1792<<4; rd_addr = 1023 -> 2815<<4, each one cycle later.
3. Decimation: same ramp, decim = 3 -> consecutive rd_addr values differ by 4 codes; rd_addr = 256 returns 2048<<4 or the first code >= 2048 that falls on a kept sample.
4. Auto timeout: constant code 100, trig_level = 2048, mode auto -> frame_ready after 256 + 2048 + 767 dsamples, triggered = 0, all rd_data = 100<<4.
5. Single mode, falling edge: ramp 4095 down to 0, trig_level = 1000, trig_slope = 0 -> rd_addr = 256 gives 1000<<4. After frame_ack: busy = 0, frame_ready = 0, no new frame despite further crossings until arm.
6. Hysteresis (CAPTURE_TRIG_HYST_EN, HYST = 8, level 2048): signal sequence 2040, 2050, 2045, 2060 after PREFILL.
   - With the macro: no trigger until the signal dips below 2040.
   - Without the macro: trigger at 2050.
